// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises icache read misses and dcache read/write traffic
// onto one single-port RAM. dcache wins arbitration unless icache has been
// passed over STARVE_MAX times in a row.
// Ports:
//   CLK, nRST               clock (rising edge), async active-low reset
//   iREN/iaddr -> iwait/iload               icache read channel
//   dREN/dWEN/daddr/dstore -> dwait/dload   dcache read/write channel
//   ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate   RAM side
//   ramerr                  sticky flag: RAM reported ERROR since reset
// Optional: define MEMARB_STATS_EN to add icount/dcount completion counters.
module memory_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ramerr
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount
`endif
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, ISERVE, DSERVE} state_t;

  state_t        state, next_state;
  logic [SW-1:0] streak, next_streak;
  logic          err_seen;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
      ramerr <= 1'b0;
    end else begin
      state  <= next_state;
      streak <= next_streak;
      if (err_seen) ramerr <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    next_streak = streak;
    err_seen    = 1'b0;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = '0;
    dload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    unique case (state)
      IDLE: begin
        // dcache yields only once icache has been starved STARVE_MAX times.
        if ((dREN || dWEN) && !(iREN && streak == SMAX)) begin
          next_state = DSERVE;
          if (!iREN)               next_streak = '0;
          else if (streak != SMAX) next_streak = streak + 1'b1;
        end else if (iREN) begin
          next_state  = ISERVE;
          next_streak = '0;
        end
      end
      DSERVE: begin
        if (!(dREN || dWEN)) begin
          // Requester withdrew: drop the RAM enables now, no completion pulse.
          next_state = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = !dWEN;
          if (ramstate == RS_ACCESS) begin
            dwait      = 1'b0;
            dload      = ramload;
            next_state = IDLE;
          end else if (ramstate == RS_ERROR) begin
            // Go back to IDLE; the still-held request is arbitrated again.
            err_seen   = 1'b1;
            next_state = IDLE;
          end
        end
      end
      ISERVE: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RS_ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            next_state = IDLE;
          end else if (ramstate == RS_ERROR) begin
            err_seen   = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef MEMARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (!iwait) icount <= icount + 32'd1;
      if (!dwait) dcount <= dcount + 32'd1;
    end
  end
`endif

endmodule
